// File: rtl/paso32bto8b_pkg.sv
// Shared definitions for the arbiter that feeds the paso32bto8b serializer.
//
// Contents:
//   estado_t      - arbiter FSM states (IDLE = no owner, RAFAGA = burst in progress)
//   K28_5         - 8b/10b comma character used as the idle byte
//   IDLE_PALABRA  - a full 32-bit word of idle commas
//   ancho_id()    - bits needed to index a given number of channels (minimum 1)
package paso32bto8b_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RAFAGA = 1'b1
    } estado_t;

    localparam logic [7:0]  K28_5        = 8'hBC;
    localparam logic [31:0] IDLE_PALABRA = {4{K28_5}};

    // A single channel still needs one index bit so that vectors never collapse to zero width.
    function automatic int ancho_id(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prioridad.sv
// Combinational round-robin picker.
//
// Ports:
//   req      in  N_CANALES  per-channel request
//   puntero  in  PW         last granted channel; the search starts one above it
//   hit      out 1          some channel is requesting
//   indice   out PW         first requesting channel found, wrapping from puntero+1
//
// The channel named by puntero is examined last, so a lone requester that just held
// the grant is still found.
module rr_prioridad
    import paso32bto8b_pkg::*;
#(
    parameter int N_CANALES = 4,
    parameter int PW        = ancho_id(N_CANALES)
) (
    input  logic [N_CANALES-1:0] req,
    input  logic [PW-1:0]        puntero,
    output logic                 hit,
    output logic [PW-1:0]        indice
);

    // The loop walks from the farthest offset to the nearest one. The nearest requester
    // is written last and therefore wins, which avoids needing an early exit.
    always_comb begin
        hit    = 1'b0;
        indice = '0;
        for (int k = N_CANALES; k >= 1; k--) begin
            int c;
            c = (int'(puntero) + k) % N_CANALES;
            if (req[c]) begin
                hit    = 1'b1;
                indice = PW'(c);
            end
        end
    end

endmodule

// File: rtl/arbitro_paso32bto8b.sv
// Round-robin arbiter and sequencer in front of the paso32bto8b serializer.
//
// Ports:
//   clk_f      in  1                  word-rate clock
//   reset      in  1                  synchronous, active-high
//   req        in  N_CANALES          per-channel word available
//   data_in    in  N_CANALES*ANCHO    flattened words, channel i at [i*ANCHO +: ANCHO]
//   pausa      in  1                  downstream stall; nothing is popped while high
//   pop        out N_CANALES          one-hot combinational read strobe for the granted channel
//   data_out   out ANCHO              registered word for the serializer
//   valid_0    out 1                  registered, qualifies data_out
//   canal_out  out 3                  registered channel ID of data_out
//   ocupado    out 1                  registered, high while a burst owner exists
//
// Optional build macro IDLE_COMMA_EN: when defined, every cycle without a grant loads
// data_out with K28_5 commas and clears canal_out; otherwise both hold their last value.
module arbitro_paso32bto8b #(
    parameter int N_CANALES  = 4,
    parameter int ANCHO      = 32,
    parameter int MAX_RAFAGA = 4
) (
    input  logic                       clk_f,
    input  logic                       reset,
    input  logic [N_CANALES-1:0]       req,
    input  logic [N_CANALES*ANCHO-1:0] data_in,
    input  logic                       pausa,
    output logic [N_CANALES-1:0]       pop,
    output logic [ANCHO-1:0]           data_out,
    output logic                       valid_0,
    output logic [2:0]                 canal_out,
    output logic                       ocupado
);

    import paso32bto8b_pkg::*;

    localparam int         PW        = ancho_id(N_CANALES);
    localparam logic [3:0] MAX_CONT  = 4'(MAX_RAFAGA);

    estado_t         estado, estado_sig;
    logic [PW-1:0]   dueno, dueno_sig;
    logic [PW-1:0]   puntero, puntero_sig;
    logic [3:0]      cont_rafaga, cont_sig;
    logic            hit_rr;
    logic [PW-1:0]   indice_rr;
    logic            concede;
    logic [PW-1:0]   indice_concesion;

    rr_prioridad #(
        .N_CANALES (N_CANALES),
        .PW        (PW)
    ) u_rr_prioridad (
        .req     (req),
        .puntero (puntero),
        .hit     (hit_rr),
        .indice  (indice_rr)
    );

    // Grant decision. The current owner keeps the grant while it still requests and has
    // burst budget left; otherwise the picker hands over in the same cycle, so rotation
    // never inserts a bubble. Reset and pausa freeze everything and grant nothing.
    always_comb begin
        estado_sig       = estado;
        dueno_sig        = dueno;
        puntero_sig      = puntero;
        cont_sig         = cont_rafaga;
        concede          = 1'b0;
        indice_concesion = dueno;
        if (!reset && !pausa) begin
            if (estado == RAFAGA && req[dueno] && cont_rafaga < MAX_CONT) begin
                concede  = 1'b1;
                cont_sig = cont_rafaga + 4'd1;
            end else if (hit_rr) begin
                concede          = 1'b1;
                indice_concesion = indice_rr;
                dueno_sig        = indice_rr;
                puntero_sig      = indice_rr;
                cont_sig         = 4'd1;
                estado_sig       = RAFAGA;
            end else begin
                estado_sig = IDLE;
                cont_sig   = 4'd0;
            end
        end
    end

    // The read strobe goes out in the grant cycle so the FIFO word is captured at the next edge.
    always_comb begin
        pop = '0;
        if (concede) begin
            pop[indice_concesion] = 1'b1;
        end
    end

    // FSM, burst counter and round-robin pointer. Pointer resets to the last channel so
    // that channel 0 is searched first.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            estado      <= IDLE;
            dueno       <= '0;
            puntero     <= PW'(N_CANALES - 1);
            cont_rafaga <= 4'd0;
        end else begin
            estado      <= estado_sig;
            dueno       <= dueno_sig;
            puntero     <= puntero_sig;
            cont_rafaga <= cont_sig;
        end
    end

    // Output registers: one cycle of latency from pop to valid_0.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            data_out  <= '0;
            valid_0   <= 1'b0;
            canal_out <= 3'd0;
            ocupado   <= 1'b0;
        end else begin
            ocupado <= (estado_sig == RAFAGA);
            if (concede) begin
                data_out  <= data_in[indice_concesion*ANCHO +: ANCHO];
                canal_out <= 3'(indice_concesion);
                valid_0   <= 1'b1;
            end else begin
                valid_0 <= 1'b0;
`ifdef IDLE_COMMA_EN
                data_out  <= ANCHO'(IDLE_PALABRA);
                canal_out <= 3'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arbitro_paso32bto8b.sv
// Self-checking bench for arbitro_paso32bto8b (N_CANALES=4, ANCHO=32, MAX_RAFAGA=4).
// A behavioural model predicts each cycle's grant; expected registered outputs are queued
// and a separate monitor compares them one cycle later. Honours IDLE_COMMA_EN if defined.
module tb_arbitro_paso32bto8b;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MAX = 4;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [2:0]  canal;
        logic        ocup;
    } esperado_t;

    logic            clk_f;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic            pausa;
    logic [N-1:0]    pop;
    logic [W-1:0]    data_out;
    logic            valid_0;
    logic [2:0]      canal_out;
    logic            ocupado;

    esperado_t       sb[$];
    int              checks;
    int              failures;

    // Reference model state: owner index (-1 when idle), words granted in the current burst,
    // last granted channel, and the value the output register should hold.
    int              m_owner;
    int              m_count;
    int              m_ptr;
    logic [31:0]     m_data;
    logic [2:0]      m_canal;

    logic [31:0]     palabra[N];
    logic            use_fixed;
    logic [31:0]     fixed_word;

    arbitro_paso32bto8b #(
        .N_CANALES  (N),
        .ANCHO      (W),
        .MAX_RAFAGA (MAX)
    ) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .pausa     (pausa),
        .pop       (pop),
        .data_out  (data_out),
        .valid_0   (valid_0),
        .canal_out (canal_out),
        .ocupado   (ocupado)
    );

    initial begin
        clk_f = 1'b0;
        forever #5 clk_f = ~clk_f;
    end

    task automatic checkOutput(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", nombre, $time, actual, esperado);
        end
    endtask

    // Which channel the arbitration rules grant this cycle (-1 for none), updating model state.
    function automatic int modelStep(input logic r, input logic [N-1:0] q, input logic p);
        int g;
        g = -1;
        if (r) begin
            m_owner = -1;
            m_count = 0;
            m_ptr   = N - 1;
        end else if (!p) begin
            if (m_owner >= 0 && q[m_owner] && m_count < MAX) begin
                g = m_owner;
                m_count++;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && q[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
                if (g >= 0) begin
                    m_owner = g;
                    m_ptr   = g;
                    m_count = 1;
                end else begin
                    m_owner = -1;
                    m_count = 0;
                end
            end
        end
        return g;
    endfunction

    // Drives one cycle of inputs, checks the combinational pop and queues the registered outcome.
    task automatic applyStimulus(input logic r, input logic [N-1:0] q, input logic p);
        int          g;
        logic [N-1:0] pop_esp;
        esperado_t   e;
        @(negedge clk_f);
        reset = r;
        req   = q;
        pausa = p;
        for (int i = 0; i < N; i++) begin
            palabra[i] = use_fixed ? fixed_word : $urandom;
            data_in[i*W +: W] = palabra[i];
        end
        #1;
        g = modelStep(r, q, p);
        pop_esp = '0;
        if (g >= 0) pop_esp[g] = 1'b1;
        checkOutput("pop", 32'(pop), 32'(pop_esp));
        if (r) begin
            m_data  = '0;
            m_canal = '0;
            e.valid = 1'b0;
        end else if (g >= 0) begin
            m_data  = palabra[g];
            m_canal = 3'(g);
            e.valid = 1'b1;
        end else begin
            e.valid = 1'b0;
`ifdef IDLE_COMMA_EN
            m_data  = 32'hBCBCBCBC;
            m_canal = 3'd0;
`endif
        end
        e.data  = m_data;
        e.canal = m_canal;
        e.ocup  = (m_owner >= 0);
        sb.push_back(e);
    endtask

    // Monitor: after every active edge, compare the registers against the oldest queued expectation.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clk_f);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("valid_0", 32'(valid_0), 32'(e.valid));
                checkOutput("data_out", data_out, e.data);
                checkOutput("canal_out", 32'(canal_out), 32'(e.canal));
                checkOutput("ocupado", 32'(ocupado), 32'(e.ocup));
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        req        = '0;
        pausa      = 1'b0;
        data_in    = '0;
        use_fixed  = 1'b0;
        fixed_word = '0;
        m_owner    = -1;
        m_count    = 0;
        m_ptr      = N - 1;
        m_data     = '0;
        m_canal    = '0;

        $display("[TB] reset");
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0);

        $display("[TB] all channels requesting");
        repeat (18) applyStimulus(1'b0, 4'b1111, 1'b0);

        $display("[TB] single requester across burst boundaries");
        use_fixed  = 1'b1;
        fixed_word = 32'hDEADBEEF;
        repeat (10) applyStimulus(1'b0, 4'b0100, 1'b0);
        use_fixed  = 1'b0;

        $display("[TB] pause mid-burst");
        applyStimulus(1'b1, 4'b0000, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0010, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b0110, 1'b1);
        repeat (5) applyStimulus(1'b0, 4'b0110, 1'b0);

        $display("[TB] owner drops request");
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b0010, 1'b0);

        $display("[TB] reset mid-burst");
        repeat (2) applyStimulus(1'b0, 4'b1000, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b1001, 1'b0);

        $display("[TB] no requests");
        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                          4'($urandom),
                          ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
        end

        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0);
        @(posedge clk_f);
        #3;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
